// File: rtl/instr_decode_stage_if.sv
// Fetch-to-execute handshake bundle for the decode stage, plus the writeback
// and flush sideband lines that steer its hazard scoreboard.
interface instr_decode_stage_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;

   logic        out_valid;
   logic        out_ready;
   logic [5:0]  out_opsel;
   logic [3:0]  out_rd;
   logic [3:0]  out_rs1;
   logic [3:0]  out_rs2;
   logic [31:0] out_imm;
   logic        out_use_imm;
   logic        out_reg_we;
   logic        out_mem_rd;
   logic        out_mem_wr;
   logic        out_branch;
   logic        out_jal;
   logic        out_illegal;
   logic [31:0] out_pc;

   logic        wb_valid;
   logic [3:0]  wb_rd;
   logic        flush;

   modport master (
      output in_valid, in_instr, in_pc, out_ready, wb_valid, wb_rd, flush,
      input  in_ready, out_valid, out_opsel, out_rd, out_rs1, out_rs2, out_imm,
             out_use_imm, out_reg_we, out_mem_rd, out_mem_wr, out_branch,
             out_jal, out_illegal, out_pc
   );

   modport slave (
      input  in_valid, in_instr, in_pc, out_ready, wb_valid, wb_rd, flush,
      output in_ready, out_valid, out_opsel, out_rd, out_rs1, out_rs2, out_imm,
             out_use_imm, out_reg_we, out_mem_rd, out_mem_wr, out_branch,
             out_jal, out_illegal, out_pc
   );
endinterface

// File: rtl/instr_decode_stage.sv
// Single-entry decode stage: decodes the fetched word, stalls on RAW hazards
// against a 16-entry destination scoreboard, and holds one bundle for execute.
module instr_decode_stage (
   input logic                 clk,
   input logic                 reset,
   instr_decode_stage_if.slave bus
);

   localparam logic [3:0] CLS_ALU_R = 4'h0;
   localparam logic [3:0] CLS_CMP_R = 4'h2;
   localparam logic [3:0] CLS_SW    = 4'h5;
   localparam logic [3:0] CLS_BR    = 4'h6;
   localparam logic [3:0] CLS_ALU_I = 4'h8;
   localparam logic [3:0] CLS_LW    = 4'h9;
   localparam logic [3:0] CLS_CMP_I = 4'hA;
   localparam logic [3:0] CLS_JAL   = 4'hB;

   typedef struct packed {
      logic [5:0]  opsel;
      logic [3:0]  rd;
      logic [3:0]  rs1;
      logic [3:0]  rs2;
      logic [31:0] imm;
      logic        use_imm;
      logic        reg_we;
      logic        mem_rd;
      logic        mem_wr;
      logic        branch;
      logic        jal;
      logic        illegal;
      logic [31:0] pc;
   } bundle_t;

   logic [3:0]  cls;
   logic [3:0]  fn;
   logic        alu_fn_ok;
   logic        use_rs1;
   logic        use_rs2;
   logic        rs1_busy;
   logic        rs2_busy;
   logic        hazard;
   logic        accept;
   bundle_t     dec;
   bundle_t     out_q;
   logic        out_valid_q;
   logic [15:0] scoreboard;
   logic [15:0] sb_next;

   assign cls       = bus.in_instr[31:28];
   assign fn        = bus.in_instr[27:24];
   assign alu_fn_ok = fn inside {4'h0, 4'h1, 4'h4, 4'h5, 4'h6, 4'hB, 4'hC, 4'hD, 4'hE};

   // NOTE: every output of a combinational block gets a default first, so no path leaves a latch.
   always_comb begin
      dec     = '0;
      dec.rd  = bus.in_instr[23:20];
      dec.rs1 = bus.in_instr[19:16];
      dec.rs2 = bus.in_instr[15:12];
      dec.imm = {{16{bus.in_instr[15]}}, bus.in_instr[15:0]};
      dec.pc  = bus.in_pc;
      use_rs1 = 1'b1;
      use_rs2 = 1'b0;
      case (cls)
         CLS_ALU_R: begin dec.opsel = {2'b00, fn}; dec.reg_we = 1'b1; use_rs2 = 1'b1; end
         CLS_ALU_I: begin dec.opsel = {2'b00, fn}; dec.use_imm = 1'b1; dec.reg_we = 1'b1; end
         CLS_CMP_R: begin dec.opsel = {2'b01, fn}; dec.reg_we = 1'b1; use_rs2 = 1'b1; end
         CLS_CMP_I: begin dec.opsel = {2'b01, fn}; dec.use_imm = 1'b1; dec.reg_we = 1'b1; end
         CLS_BR:    begin dec.opsel = {2'b01, fn}; dec.branch = 1'b1; use_rs2 = 1'b1; end
         CLS_JAL:   begin dec.opsel = 6'h20; dec.use_imm = 1'b1; dec.reg_we = 1'b1; dec.jal = 1'b1; end
         CLS_LW:    begin dec.use_imm = 1'b1; dec.mem_rd = 1'b1; dec.reg_we = 1'b1; end
         CLS_SW:    begin dec.use_imm = 1'b1; dec.mem_wr = 1'b1; use_rs2 = 1'b1; end
         default:   begin dec.illegal = 1'b1; use_rs1 = 1'b0; end
      endcase
      // An unknown ALU function keeps its class routing but must never retire a write.
      if ((cls == CLS_ALU_R || cls == CLS_ALU_I) && !alu_fn_ok) begin
         dec.illegal = 1'b1;
         dec.reg_we  = 1'b0;
      end
   end

   // A writeback landing this cycle releases its register early (bypass).
   assign rs1_busy = use_rs1 && scoreboard[dec.rs1] && !(bus.wb_valid && bus.wb_rd == dec.rs1);
   assign rs2_busy = use_rs2 && scoreboard[dec.rs2] && !(bus.wb_valid && bus.wb_rd == dec.rs2);
   assign hazard   = rs1_busy || rs2_busy;

   assign bus.in_ready = (!out_valid_q || bus.out_ready) && !hazard && !bus.flush && !reset;
   assign accept       = bus.in_valid && bus.in_ready;

   // Later statements win: flush-clear overrides wb-clear, and a new set overrides both.
   always_comb begin
      sb_next = scoreboard;
      if (bus.wb_valid)
         sb_next[bus.wb_rd] = 1'b0;
      if (bus.flush && out_valid_q && out_q.reg_we)
         sb_next[out_q.rd] = 1'b0;
      if (accept && dec.reg_we)
         sb_next[dec.rd] = 1'b1;
   end

   // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_q       <= '0;
         scoreboard  <= '0;
      end else begin
         scoreboard <= sb_next;
         if (accept) begin
            out_valid_q <= 1'b1;
            out_q       <= dec;
         end else if (bus.flush || bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign bus.out_valid   = out_valid_q;
   assign bus.out_opsel   = out_q.opsel;
   assign bus.out_rd      = out_q.rd;
   assign bus.out_rs1     = out_q.rs1;
   assign bus.out_rs2     = out_q.rs2;
   assign bus.out_imm     = out_q.imm;
   assign bus.out_use_imm = out_q.use_imm;
   assign bus.out_reg_we  = out_q.reg_we;
   assign bus.out_mem_rd  = out_q.mem_rd;
   assign bus.out_mem_wr  = out_q.mem_wr;
   assign bus.out_branch  = out_q.branch;
   assign bus.out_jal     = out_q.jal;
   assign bus.out_illegal = out_q.illegal;
   assign bus.out_pc      = out_q.pc;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed scenarios plus randomized traffic for instr_decode_stage, checked
// cycle by cycle against a behavioural model of the decode rules.
module tb_instr_decode_stage;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   instr_decode_stage_if bus ();
   instr_decode_stage dut (.clk(clk), .reset(reset), .bus(bus));

   typedef struct packed {
      logic [5:0]  opsel;
      logic [3:0]  rd;
      logic [3:0]  rs1;
      logic [3:0]  rs2;
      logic [31:0] imm;
      logic        use_imm;
      logic        reg_we;
      logic        mem_rd;
      logic        mem_wr;
      logic        branch;
      logic        jal;
      logic        illegal;
      logic [31:0] pc;
   } bundle_t;

   int          errors = 0;
   int          checks = 0;
   bit          m_valid;
   bundle_t     m_out;
   logic [15:0] m_sb;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference decode straight from the class table.
   function automatic bundle_t model_decode(input logic [31:0] instr, input logic [31:0] pc,
                                            output bit u1, output bit u2);
      bundle_t    b;
      logic [3:0] c;
      logic [3:0] f;
      int         ok_fn[$];
      c = instr[31:28];
      f = instr[27:24];
      ok_fn = '{0, 1, 4, 5, 6, 11, 12, 13, 14};
      b = '0;
      b.rd  = instr[23:20];
      b.rs1 = instr[19:16];
      b.rs2 = instr[15:12];
      b.imm = {{16{instr[15]}}, instr[15:0]};
      b.pc  = pc;
      u1 = 1'b1;
      u2 = 1'b0;
      case (c)
         4'h0: begin b.opsel = {2'b00, f}; b.reg_we = 1; u2 = 1; end
         4'h8: begin b.opsel = {2'b00, f}; b.use_imm = 1; b.reg_we = 1; end
         4'h2: begin b.opsel = {2'b01, f}; b.reg_we = 1; u2 = 1; end
         4'hA: begin b.opsel = {2'b01, f}; b.use_imm = 1; b.reg_we = 1; end
         4'h6: begin b.opsel = {2'b01, f}; b.branch = 1; u2 = 1; end
         4'hB: begin b.opsel = 6'h20; b.use_imm = 1; b.reg_we = 1; b.jal = 1; end
         4'h9: begin b.use_imm = 1; b.mem_rd = 1; b.reg_we = 1; end
         4'h5: begin b.use_imm = 1; b.mem_wr = 1; u2 = 1; end
         default: begin b.illegal = 1; u1 = 0; end
      endcase
      if ((c == 4'h0 || c == 4'h8) && !(int'(f) inside {ok_fn})) begin
         b.illegal = 1;
         b.reg_we  = 0;
      end
      return b;
   endfunction

   function automatic bit src_stalls(input bit used, input logic [3:0] idx);
      return used && m_sb[idx] && !(bus.wb_valid && bus.wb_rd == idx);
   endfunction

   function automatic bundle_t dut_bundle();
      bundle_t b;
      b.opsel = bus.out_opsel;   b.rd = bus.out_rd;   b.rs1 = bus.out_rs1;
      b.rs2 = bus.out_rs2;       b.imm = bus.out_imm; b.use_imm = bus.out_use_imm;
      b.reg_we = bus.out_reg_we; b.mem_rd = bus.out_mem_rd; b.mem_wr = bus.out_mem_wr;
      b.branch = bus.out_branch; b.jal = bus.out_jal; b.illegal = bus.out_illegal;
      b.pc = bus.out_pc;
      return b;
   endfunction

   // One clock: check in_ready, advance the model across the edge, check state.
   task automatic cycle();
      bundle_t     d;
      bit          u1, u2, rdy, acc;
      logic [15:0] sb_n;
      #1;
      d   = model_decode(bus.in_instr, bus.in_pc, u1, u2);
      rdy = (!m_valid || bus.out_ready) && !src_stalls(u1, d.rs1) && !src_stalls(u2, d.rs2)
            && !bus.flush && !reset;
      acc = bus.in_valid && rdy;
      check("in_ready", 128'(bus.in_ready), 128'(rdy));
      sb_n = m_sb;
      if (bus.wb_valid) sb_n[bus.wb_rd] = 1'b0;
      if (bus.flush && m_valid && m_out.reg_we) sb_n[m_out.rd] = 1'b0;
      if (acc && d.reg_we) sb_n[d.rd] = 1'b1;
      @(posedge clk);
      if (reset) begin
         m_valid = 0; m_out = '0; m_sb = '0;
      end else begin
         m_sb = sb_n;
         if (acc) begin
            m_valid = 1; m_out = d;
         end else if (bus.flush || (m_valid && bus.out_ready)) begin
            m_valid = 0;
         end
      end
      #1;
      check("out_valid", 128'(bus.out_valid), 128'(m_valid));
      check("bundle", 128'(dut_bundle()), 128'(m_out));
      check("scoreboard", 128'(dut.scoreboard), 128'(m_sb));
   endtask

   task automatic do_reset();
      reset = 1; bus.in_valid = 0; bus.flush = 0; bus.wb_valid = 0; bus.out_ready = 1;
      cycle();
      cycle();
      reset = 0;
   endtask

   task automatic present(input logic [31:0] instr, input logic [31:0] pc);
      bus.in_valid = 1; bus.in_instr = instr; bus.in_pc = pc;
   endtask

   initial begin
      reset = 1;
      bus.in_valid = 0; bus.in_instr = '0; bus.in_pc = '0; bus.out_ready = 0;
      bus.wb_valid = 0; bus.wb_rd = '0; bus.flush = 0;
      m_valid = 0; m_out = '0; m_sb = '0;

      do_reset();
      check("reset_valid", 128'(bus.out_valid), 128'(0));
      check("reset_sb", 128'(dut.scoreboard), 128'(0));

      // NAND rd=3 rs1=1 rs2=2
      present(32'h0C312000, 32'h100);
      cycle();
      check("nand_opsel", 128'(bus.out_opsel), 128'(6'h0C));
      check("nand_rd", 128'(bus.out_rd), 128'(3));
      check("nand_we", 128'(bus.out_reg_we), 128'(1));
      check("nand_sb3", 128'(dut.scoreboard[3]), 128'(1));

      // RAW stall on rd=5, released by a same-cycle writeback
      do_reset();
      present(32'h00500000, 32'h200);
      cycle();
      present(32'h00650000, 32'h204);
      #1 check("raw_stall", 128'(bus.in_ready), 128'(0));
      cycle();
      bus.wb_valid = 1; bus.wb_rd = 4'd5;
      #1 check("raw_bypass", 128'(bus.in_ready), 128'(1));
      cycle();
      bus.wb_valid = 0;

      do_reset();
      present(32'h8021FFFC, 32'h300);
      cycle();
      check("addi_imm", 128'(bus.out_imm), 128'(32'hFFFFFFFC));
      check("addi_use_imm", 128'(bus.out_use_imm), 128'(1));
      present(32'hB0E00004, 32'h304);
      cycle();
      check("jal_opsel", 128'(bus.out_opsel), 128'(6'h20));
      check("jal_flag", 128'(bus.out_jal), 128'(1));
      present(32'h02000000, 32'h308);
      cycle();
      check("badfn_illegal", 128'(bus.out_illegal), 128'(1));
      check("badfn_we", 128'(bus.out_reg_we), 128'(0));

      // Backpressure: hold bundle A while B waits
      do_reset();
      bus.out_ready = 0;
      present(32'h00312000, 32'h400);
      cycle();
      present(32'h01745000, 32'h404);
      for (int i = 0; i < 3; i++) begin
         #1 check("bp_ready", 128'(bus.in_ready), 128'(0));
         cycle();
         check("bp_hold_pc", 128'(bus.out_pc), 128'(32'h400));
      end
      bus.out_ready = 1;
      cycle();
      check("bp_next_pc", 128'(bus.out_pc), 128'(32'h404));
      check("bp_next_valid", 128'(bus.out_valid), 128'(1));

      // Flush a held rd=7 bundle; then set-wins on rd=4
      do_reset();
      bus.out_ready = 0;
      present(32'h00712000, 32'h500);
      cycle();
      bus.in_valid = 0; bus.flush = 1;
      cycle();
      bus.flush = 0;
      check("flush_valid", 128'(bus.out_valid), 128'(0));
      check("flush_sb7", 128'(dut.scoreboard[7]), 128'(0));
      bus.out_ready = 1;
      present(32'h00412000, 32'h504);
      bus.wb_valid = 1; bus.wb_rd = 4'd4;
      cycle();
      bus.wb_valid = 0;
      check("set_wins_sb4", 128'(dut.scoreboard[4]), 128'(1));

      // Illegal class passes through; reset discards the held bundle
      do_reset();
      present(32'h00812000, 32'h600);
      cycle();
      present(32'h40000000, 32'h604);
      cycle();
      bus.in_valid = 0; bus.out_ready = 0;
      cycle();
      check("illegal_flag", 128'(bus.out_illegal), 128'(1));
      check("illegal_we", 128'(bus.out_reg_we), 128'(0));
      check("illegal_valid", 128'(bus.out_valid), 128'(1));
      reset = 1;
      cycle();
      reset = 0;
      check("rst_hold_valid", 128'(bus.out_valid), 128'(0));
      check("rst_hold_sb", 128'(dut.scoreboard), 128'(0));

      // Random traffic, legal classes favoured
      for (int n = 0; n < 600; n++) begin
         logic [3:0]  cls_pool [10];
         logic [31:0] r;
         cls_pool = '{4'h0, 4'h8, 4'h2, 4'hA, 4'h6, 4'hB, 4'h9, 4'h5, 4'h4, 4'hF};
         r = $urandom;
         bus.in_instr  = {cls_pool[$urandom_range(0, 9)], r[27:0]};
         bus.in_pc     = bus.in_pc + 32'd4;
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         bus.wb_valid  = ($urandom_range(0, 1) != 0);
         bus.wb_rd     = 4'($urandom);
         bus.flush     = ($urandom_range(0, 15) == 0);
         reset         = ($urandom_range(0, 63) == 0);
         cycle();
      end
      reset = 0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/instr_decode_stage.md
INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

Interface
REQ-001 The block SHALL have these ports, one clock domain; reset is synchronous and active-high:
- clk  in  1  sole clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  decode accepts the instruction this cycle
- in_instr  in  32  instruction word
- in_pc  in  32  byte address of in_instr
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute stage consumes the bundle this cycle
- out_opsel  out  6  ALU operation select: ADD=00, SUB=01, AND=04, OR=05, XOR=06, MVHI=0B, NAND=0C, NOR=0D, XNOR=0E, compares 10-1F, JAL=20
- out_rd, out_rs1, out_rs2  out  4 each  register indices
- out_imm  out  32  sign-extended imm16
- out_use_imm  out  1  ALU B operand is out_imm, not rs2
- out_reg_we, out_mem_rd, out_mem_wr, out_branch, out_jal, out_illegal  out  1 each  control flags
- out_pc  out  32  in_pc of the bundle
- wb_valid  in  1  writeback retires a register write
- wb_rd  in  4  register written back
- flush  in  1  discard the held bundle (taken branch/JAL)

Function
REQ-002 Field decoding SHALL be: cls=instr[31:28], fn=instr[27:24], rd=[23:20], rs1=[19:16], rs2=[15:12], imm16=[15:0].
REQ-003 Class mapping SHALL be:
- 0 ALU-R: opsel={2'b00,fn}, reg_we.
- 8 ALU-I: opsel={2'b00,fn}, use_imm, reg_we.
- 2 CMP-R: opsel={2'b01,fn}, reg_we.
- A CMP-I: opsel={2'b01,fn}, use_imm, reg_we.
- 6 BR: opsel={2'b01,fn}, branch; rs1 and rs2 compared; imm is word offset.
- B JAL: opsel=6'h20, use_imm, reg_we, jal.
- 9 LW: opsel=6'h00, use_imm, mem_rd, reg_we.
- 5 SW: opsel=6'h00, use_imm, mem_wr.
REQ-004 Any other cls SHALL set out_illegal=1 with every other control flag 0 and opsel=6'h00.
REQ-005 An ALU-R or ALU-I fn outside {0,1,4,5,6,B,C,D,E} SHALL set out_illegal=1 and out_reg_we=0.
REQ-006 Source usage SHALL be:
- rs1 used by every legal class.
- rs2 used only by ALU-R, CMP-R, BR and SW.
REQ-007 The output register SHALL load on a handshake (in_valid & in_ready); latency is exactly 1 cycle from accept to out_valid=1.
REQ-008 in_ready SHALL equal (!out_valid | out_ready) & !hazard & !flush & !reset, as combinational logic.
REQ-009 While out_valid=1 and out_ready=0, every out_* signal SHALL hold stable.
REQ-010 When out_valid & out_ready occurs with no new accept, out_valid SHALL clear next cycle.
REQ-011 A 16-bit scoreboard SHALL track destination registers:
- Set bit rd when a legal reg_we instruction is accepted.
- Clear bit wb_rd when wb_valid=1.
- If set and clear hit the same index in one cycle, set wins.
REQ-012 hazard SHALL be 1 when a used source index has its scoreboard bit set, unless wb_valid=1 and wb_rd equals that index in the same cycle (bypass).
REQ-013 When hazard=1, in_ready SHALL be 0 and the instruction SHALL be held; no bubble is recorded and no scoreboard change occurs.
REQ-014 flush=1 SHALL:
- Clear out_valid next cycle.
- Block accept that cycle.
- Clear the scoreboard bit set by the discarded bundle (if out_reg_we=1), with priority over a same-index wb clear.
REQ-015 An illegal instruction SHALL still pass through the handshake so that execute raises the exception.

Reset
REQ-016 Reset SHALL force, on the next clock edge:
- out_valid=0 and scoreboard=16'h0000.
- All out_* data and flags to 0.
- in_ready=0 while reset is asserted.
REQ-017 Reset asserted mid-stall or mid-hold SHALL discard the held bundle with no writeback expectation.

Verification
REQ-018 ALU-R: in_instr=32'h0C312000 (NAND, rd=3, rs1=1, rs2=2), out_ready=1 -> next cycle out_valid=1, out_opsel=0C, out_rd=3, out_reg_we=1, scoreboard[3]=1.
REQ-019 RAW stall: accept ADD rd=5, then present rs1=5 with no writeback -> in_ready=0. Then pulse wb_valid=1, wb_rd=5 -> in_ready=1 in that same cycle.
REQ-020 Immediate: in_instr=32'h8021FFFC (ADDI rd=2, rs1=1) -> out_imm=32'hFFFFFFFC, out_use_imm=1; in_instr=32'hB0E00004 -> out_opsel=20, out_jal=1.
REQ-021 Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, in_ready=0; out_ready=1 -> next bundle loaded in 1 cycle.
REQ-022 Flush with the held bundle having rd=7: flush=1 -> out_valid=0 and scoreboard[7]=0 next cycle. Separately, set rd=4 concurrent with wb_rd=4 -> bit 4 remains 1.
REQ-023 Illegal instructions: cls=4 -> out_illegal=1, out_reg_we=0. Reset pulsed with a held bundle -> out_valid=0, scoreboard=0.
